fm_discriminator: RTL

- Baseband FM demodulator that sits directly upstream of the de-emphasis low-pass filter.
- Takes complex I/Q samples from the channel filter and computes each sample's phase with an iterative CORDIC in vectoring mode.
- Outputs the sample-to-sample phase difference, i.e. instantaneous frequency, as a signed word of the same width that the de-emphasis stage consumes.
- One sample is processed at a time; a valid strobe paces the block.

---
 rtl/fm_pkg.sv | 73 +++++++
 rtl/fm_discriminator_cordic_vectoring.sv | 117 +++++++++++
 rtl/fm_discriminator.sv | 94 +++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// fm_pkg: shared types and constants for the FM discriminator.
//   phase_t        - phase word, unsigned wrap, 2^(FM_WIDTH-1) = pi
//   PI_PHASE       - pi in phase_t units
//   atan_lut(k,w)  - round(atan(2^-k)/pi * 2^(w-1)), elaboration-time constant
//   disc_state_t / cordic_state_t / fm_dbg_t - FSM encodings and debug view
package fm_pkg;

  localparam int FM_WIDTH = 16;

  typedef logic [FM_WIDTH-1:0] phase_t;

  localparam phase_t PI_PHASE = {1'b1, {(FM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DIFF = 2'd2
  } disc_state_t;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_PREROT = 2'd1,
    C_ITER   = 2'd2
  } cordic_state_t;

  typedef struct packed {
    disc_state_t   disc;
    cordic_state_t cordic;
  } fm_dbg_t;

  // Master table holds atan(2^-k) with 2^31 = pi; narrower phase words are
  // obtained by rounding the table down to the requested width.
  function automatic int unsigned atan_lut(input int k, input int width);
    int unsigned t;
    case (k)
      0:  t = 32'd536870912;
      1:  t = 32'd316933406;
      2:  t = 32'd167458907;
      3:  t = 32'd85004756;
      4:  t = 32'd42667331;
      5:  t = 32'd21354465;
      6:  t = 32'd10679838;
      7:  t = 32'd5340245;
      8:  t = 32'd2670163;
      9:  t = 32'd1335087;
      10: t = 32'd667544;
      11: t = 32'd333772;
      12: t = 32'd166886;
      13: t = 32'd83443;
      14: t = 32'd41722;
      15: t = 32'd20861;
      16: t = 32'd10430;
      17: t = 32'd5215;
      18: t = 32'd2608;
      19: t = 32'd1304;
      20: t = 32'd652;
      21: t = 32'd326;
      22: t = 32'd163;
      23: t = 32'd81;
      24: t = 32'd41;
      25: t = 32'd20;
      26: t = 32'd10;
      27: t = 32'd5;
      28: t = 32'd3;
      29: t = 32'd1;
      30: t = 32'd1;
      default: t = 32'd0;
    endcase
    if (width >= 32) return t;
    return (t + (32'd1 << (31 - width))) >> (32 - width);
  endfunction

endpackage

// File: rtl/fm_discriminator_cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC returning the phase of
// (i_in, q_in).
//   clk, reset   - clock, asynchronous active-high reset
//   start        - accept i_in/q_in (only asserted by the parent while idle)
//   i_in, q_in   - signed sample
//   done         - high during the final micro-rotation cycle
//   phase        - result, valid while done is high (already includes the
//                  final rotation's contribution)
//   state_dbg    - current FSM state
module cordic_vectoring
  import fm_pkg::*;
#(
  parameter int width      = FM_WIDTH,
  parameter int iterations = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [width-1:0] i_in,
  input  logic signed [width-1:0] q_in,
  output logic                    done,
  output logic        [width-1:0] phase,
  output cordic_state_t           state_dbg
);

  localparam int XW = width + 2;  // headroom for the ~1.647 CORDIC gain
  localparam int KW = $clog2(iterations);
  localparam logic [width-1:0] PI_Z = {1'b1, {(width-1){1'b0}}};

  cordic_state_t state, state_nxt;

  logic signed [XW-1:0] x, y, x_n, y_n, x_sh, y_sh;
  logic [width-1:0]     z, z_n;
  logic [KW-1:0]        k;
  logic                 zero;  // I=Q=0 has no defined angle; report 0
  logic                 last;

  logic [width-1:0] atan_tab [iterations];
  for (genvar g = 0; g < iterations; g++) begin : g_atan
    assign atan_tab[g] = width'(atan_lut(g, width));
  end

  assign last = (k == KW'(iterations - 1));

  // One micro-rotation; shifts use the pre-update x/y.
  always_comb begin
    x_sh = x >>> k;
    y_sh = y >>> k;
    if (!y[XW-1]) begin
      x_n = x + y_sh;
      y_n = y - x_sh;
      z_n = z + atan_tab[k];
    end else begin
      x_n = x - y_sh;
      y_n = y + x_sh;
      z_n = z - atan_tab[k];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:   if (start) state_nxt = C_PREROT;
      C_PREROT: state_nxt = C_ITER;
      C_ITER:   if (last) state_nxt = C_IDLE;
      default:  state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= C_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      k    <= '0;
      zero <= 1'b0;
    end else begin
      case (state)
        C_IDLE: begin
          if (start) begin
            x <= {{2{i_in[width-1]}}, i_in};
            y <= {{2{q_in[width-1]}}, q_in};
          end
        end
        C_PREROT: begin
          k    <= '0;
          zero <= (x == '0) && (y == '0);
          // Left half-plane: rotate by pi so iterations start within +/-pi/2.
          if (x[XW-1]) begin
            x <= -x;
            y <= -y;
            z <= PI_Z;
          end else begin
            z <= '0;
          end
        end
        C_ITER: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == C_ITER) && last;
  assign phase     = zero ? '0 : z_n;
  assign state_dbg = state;

endmodule

// File: rtl/fm_discriminator.sv
// fm_discriminator: baseband FM demodulator. Each accepted I/Q sample is
// turned into a phase by the CORDIC; out is the wrapped difference from the
// previous sample's phase (full scale +/-2^(width-1) = +/-pi rad/sample).
//   clk, reset  - clock, asynchronous active-high reset
//   i_in, q_in  - signed sample, taken when in_valid is high and idle
//   in_valid    - one-cycle input strobe
//   out         - instantaneous frequency, signed, held between strobes
//   out_valid   - one-cycle strobe, iterations+2 cycles after in_valid
//   busy        - sample in flight
//   overrun     - sticky: in_valid seen while busy (sample dropped)
//   dbg         - both FSM states
// Handshake: in_valid is a one-cycle strobe with no back-pressure; it is
// honoured only when busy is low, otherwise the sample is lost and overrun
// latches. out_valid is a one-cycle strobe with no ready.
module fm_discriminator
  import fm_pkg::*;
#(
  parameter int width      = FM_WIDTH,
  parameter int iterations = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [width-1:0] i_in,
  input  logic signed [width-1:0] q_in,
  input  logic                    in_valid,
  output logic signed [width-1:0] out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun,
  output fm_dbg_t                 dbg
);

  disc_state_t      state, state_nxt;
  logic             start, done;
  logic [width-1:0] phase, prev_phase, out_q;
  cordic_state_t    cordic_state;

  cordic_vectoring #(
    .width      (width),
    .iterations (iterations)
  ) u_cordic (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .i_in      (i_in),
    .q_in      (q_in),
    .done      (done),
    .phase     (phase),
    .state_dbg (cordic_state)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          start     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN:   if (done) state_nxt = S_DIFF;
      S_DIFF:  state_nxt = S_IDLE;  // in_valid here is dropped as busy
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Width-bit wrap of the difference makes +/-pi crossings alias correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      prev_phase <= '0;
      overrun    <= 1'b0;
    end else begin
      if (done) begin
        out_q      <= phase - prev_phase;
        prev_phase <= phase;
      end
      if (in_valid && busy) overrun <= 1'b1;
    end
  end

  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_DIFF);
  assign out        = out_q;
  assign dbg.disc   = state;
  assign dbg.cordic = cordic_state;

endmodule
